// File: rtl/load_store_unit_if.sv
// Pipeline and data-memory signals of the load/store unit, bundled so that the
// unit and its environment connect through a single port.
interface load_store_unit_if #(
    parameter int ADRESS_SIZE = 32
);
    logic                   ReqValid;
    logic                   ReqReady;
    logic                   ReqWrite;
    logic [2:0]             Funct3;
    logic [ADRESS_SIZE-1:0] Adress;
    logic [31:0]            StoreData;
    logic                   RespValid;
    logic [31:0]            LoadResult;
    logic                   Fault;
    logic                   MemEn;
    logic                   WriteEnable;
    logic [3:0]             ByteEn;
    logic [ADRESS_SIZE-1:0] MemoryAdress;
    logic [31:0]            InputData;
    logic [31:0]            MemData;

    // Environment side: the pipeline issuing requests plus the memory answering them
    modport master (
        output ReqValid, ReqWrite, Funct3, Adress, StoreData, MemData,
        input  ReqReady, RespValid, LoadResult, Fault,
               MemEn, WriteEnable, ByteEn, MemoryAdress, InputData
    );

    modport slave (
        input  ReqValid, ReqWrite, Funct3, Adress, StoreData, MemData,
        output ReqReady, RespValid, LoadResult, Fault,
               MemEn, WriteEnable, ByteEn, MemoryAdress, InputData
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit in front of a word-wide byte-enabled memory;
// accesses crossing a word boundary are done as two word accesses.
module load_store_unit #(
    parameter int ADRESS_SIZE      = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input logic               clk,
    input logic               reset,
    load_store_unit_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, ACC0, ACC1, RESP, ERR} state_t;

    state_t      state;
    logic        wr;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] sdata;
    logic [6:0]  wmask;
    logic [31:0] lo;
    logic [31:0] hi;

    logic [3:0]  req_mask;
    logic [6:0]  req_wmask;
    logic        req_split;
    logic        req_illegal;

    always_comb begin
        unique case (bus.Funct3[1:0])
            2'b00:   req_mask = 4'b0001;
            2'b01:   req_mask = 4'b0011;
            default: req_mask = 4'b1111;
        endcase
        req_wmask = {3'b000, req_mask} << bus.Adress[1:0];
        req_split = |req_wmask[6:4];
        if (bus.ReqWrite)
            req_illegal = bus.Funct3 > 3'b010;
        else
            req_illegal = (bus.Funct3 == 3'b011) || (bus.Funct3 == 3'b110) ||
                          (bus.Funct3 == 3'b111);
    end

    // Align the two fetched words to the request offset and extend to 32 bits
    function automatic logic [31:0] extend(input logic [63:0] w, input logic [1:0] o,
                                           input logic [2:0] fn);
        logic [63:0] s;
        s = w >> {o, 3'b000};
        case (fn)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b010:  return s[31:0];
            3'b100:  return {24'h0, s[7:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return 32'h0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            bus.ReqReady     <= 1'b1;
            bus.RespValid    <= 1'b0;
            bus.Fault        <= 1'b0;
            bus.LoadResult   <= 32'h0;
            bus.MemEn        <= 1'b0;
            bus.WriteEnable  <= 1'b0;
            bus.ByteEn       <= 4'h0;
            bus.MemoryAdress <= '0;
            bus.InputData    <= 32'h0;
            wr               <= 1'b0;
            f3               <= 3'b000;
            off              <= 2'b00;
            sdata            <= 32'h0;
            wmask            <= 7'h0;
            lo               <= 32'h0;
            hi               <= 32'h0;
        end else begin
            bus.RespValid <= 1'b0;
            bus.Fault     <= 1'b0;
            case (state)
                IDLE: if (bus.ReqValid) begin
                    wr           <= bus.ReqWrite;
                    f3           <= bus.Funct3;
                    off          <= bus.Adress[1:0];
                    sdata        <= bus.StoreData;
                    wmask        <= req_wmask;
                    hi           <= 32'h0;
                    bus.ReqReady <= 1'b0;
                    if (req_illegal || (req_split && !ALLOW_MISALIGNED)) begin
                        state          <= ERR;
                        bus.RespValid  <= 1'b1;
                        bus.Fault      <= 1'b1;
                        bus.LoadResult <= 32'h0;
                    end else begin
                        state            <= ACC0;
                        bus.MemEn        <= 1'b1;
                        bus.WriteEnable  <= bus.ReqWrite;
                        bus.ByteEn       <= req_wmask[3:0];
                        bus.MemoryAdress <= {bus.Adress[ADRESS_SIZE-1:2], 2'b00};
                        bus.InputData    <= bus.StoreData << {bus.Adress[1:0], 3'b000};
                    end
                end
                ACC0: begin
                    lo <= bus.MemData;
                    if (|wmask[6:4]) begin
                        state            <= ACC1;
                        bus.MemoryAdress <= bus.MemoryAdress + ADRESS_SIZE'(4);
                        bus.ByteEn       <= {1'b0, wmask[6:4]};
                        bus.InputData    <= sdata >> {3'd4 - {1'b0, off}, 3'b000};
                    end else begin
                        state           <= RESP;
                        bus.MemEn       <= 1'b0;
                        bus.WriteEnable <= 1'b0;
                        bus.ByteEn      <= 4'h0;
                        bus.RespValid   <= 1'b1;
                        bus.LoadResult  <= wr ? 32'h0 : extend({hi, bus.MemData}, off, f3);
                    end
                end
                ACC1: begin
                    hi              <= bus.MemData;
                    state           <= RESP;
                    bus.MemEn       <= 1'b0;
                    bus.WriteEnable <= 1'b0;
                    bus.ByteEn      <= 4'h0;
                    bus.RespValid   <= 1'b1;
                    bus.LoadResult  <= wr ? 32'h0 : extend({bus.MemData, lo}, off, f3);
                end
                RESP, ERR: begin
                    state        <= IDLE;
                    bus.ReqReady <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: one unit with split accesses enabled against a small memory
// model, plus one unit with split accesses disabled.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic reset;
    logic mem_init;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    load_store_unit_if #(.ADRESS_SIZE(32)) b1 ();
    load_store_unit_if #(.ADRESS_SIZE(32)) b2 ();

    load_store_unit #(.ADRESS_SIZE(32), .ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .reset(reset), .bus(b1));
    load_store_unit #(.ADRESS_SIZE(32), .ALLOW_MISALIGNED(1'b0)) dut_strict (
        .clk(clk), .reset(reset), .bus(b2));

    // 16-word memory indexed by address bits [5:2]; 0xFFFFFFFC lands in word 15
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[0]  <= 32'h000000F1;
            mem[4]  <= 32'hDEADBEEF;
            mem[15] <= 32'hAB123456;
        end else if (b1.MemEn && b1.WriteEnable) begin
            for (int i = 0; i < 4; i++)
                if (b1.ByteEn[i]) mem[b1.MemoryAdress[5:2]][8*i +: 8] <= b1.InputData[8*i +: 8];
        end
    end
    assign b1.MemData = b1.MemEn ? mem[b1.MemoryAdress[5:2]] : 32'h0;
    assign b2.MemData = 32'h12345678;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Per-request capture: memory cycles seen, response latency and result
    int          n_en;
    int          lat;
    logic [3:0]  s_be [4];
    logic [31:0] s_ma [4];
    logic [31:0] s_id [4];
    logic        s_we [4];
    logic [31:0] res;
    logic        flt;

    task automatic do_req(input bit sel, input logic w, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        if (!sel) begin
            b1.ReqValid = 1'b1; b1.ReqWrite = w; b1.Funct3 = f; b1.Adress = a; b1.StoreData = d;
            chk("ready", b1.ReqReady, 1'b1);
        end else begin
            b2.ReqValid = 1'b1; b2.ReqWrite = w; b2.Funct3 = f; b2.Adress = a; b2.StoreData = d;
            chk("ready2", b2.ReqReady, 1'b1);
        end
        @(posedge clk);
        #1;
        b1.ReqValid = 1'b0;
        b2.ReqValid = 1'b0;
        n_en = 0;
        lat  = 0;
        res  = 32'hX;
        flt  = 1'bX;
        for (int k = 1; k <= 6 && lat == 0; k++) begin
            @(negedge clk);
            if (!sel ? b1.MemEn : b2.MemEn) begin
                if (n_en < 4) begin
                    s_be[n_en] = !sel ? b1.ByteEn : b2.ByteEn;
                    s_ma[n_en] = !sel ? b1.MemoryAdress : b2.MemoryAdress;
                    s_id[n_en] = !sel ? b1.InputData : b2.InputData;
                    s_we[n_en] = !sel ? b1.WriteEnable : b2.WriteEnable;
                end
                n_en++;
            end
            if (!sel ? b1.RespValid : b2.RespValid) begin
                lat = k;
                res = !sel ? b1.LoadResult : b2.LoadResult;
                flt = !sel ? b1.Fault : b2.Fault;
            end
        end
    endtask

    int pulses;

    initial begin
        reset = 1'b1; mem_init = 1'b1;
        b1.ReqValid = 1'b0; b1.ReqWrite = 1'b0; b1.Funct3 = 3'b000; b1.Adress = 32'h0; b1.StoreData = 32'h0;
        b2.ReqValid = 1'b0; b2.ReqWrite = 1'b0; b2.Funct3 = 3'b000; b2.Adress = 32'h0; b2.StoreData = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", b1.ReqReady, 1'b1);
        chk("rst_resp", b1.RespValid, 1'b0);
        chk("rst_fault", b1.Fault, 1'b0);
        chk("rst_result", b1.LoadResult, 32'h0);
        chk("rst_memen", b1.MemEn, 1'b0);
        chk("rst_we", b1.WriteEnable, 1'b0);
        chk("rst_be", b1.ByteEn, 4'h0);
        chk("rst_addr", b1.MemoryAdress, 32'h0);
        chk("rst_wdata", b1.InputData, 32'h0);
        reset = 1'b0; mem_init = 1'b0;

        // LW 0x10
        do_req(0, 1'b0, 3'b010, 32'h10, 32'h0);
        chk("lw_nmem", n_en, 1);
        chk("lw_be", s_be[0], 4'hF);
        chk("lw_addr", s_ma[0], 32'h10);
        chk("lw_we", s_we[0], 1'b0);
        chk("lw_lat", lat, 2);
        chk("lw_res", res, 32'hDEADBEEF);
        chk("lw_fault", flt, 1'b0);

        // SB 0xA5 at 0x13, then LB / LBU back
        do_req(0, 1'b1, 3'b000, 32'h13, 32'h000000A5);
        chk("sb_nmem", n_en, 1);
        chk("sb_be", s_be[0], 4'h8);
        chk("sb_addr", s_ma[0], 32'h10);
        chk("sb_wdata", s_id[0][31:24], 8'hA5);
        chk("sb_we", s_we[0], 1'b1);
        chk("sb_lat", lat, 2);
        chk("sb_res", res, 32'h0);
        do_req(0, 1'b0, 3'b000, 32'h13, 32'h0);
        chk("lb_res", res, 32'hFFFFFFA5);
        do_req(0, 1'b0, 3'b100, 32'h13, 32'h0);
        chk("lbu_res", res, 32'h000000A5);
        // Halfword in the upper half of a word: no split
        do_req(0, 1'b0, 3'b001, 32'h12, 32'h0);
        chk("lh_hi_nmem", n_en, 1);
        chk("lh_hi_res", res, 32'hFFFFA5AD);
        do_req(0, 1'b0, 3'b101, 32'h12, 32'h0);
        chk("lhu_hi_res", res, 32'h0000A5AD);

        // Split SW 0x11223344 at 0x21
        do_req(0, 1'b1, 3'b010, 32'h21, 32'h11223344);
        chk("sw_nmem", n_en, 2);
        chk("sw_addr0", s_ma[0], 32'h20);
        chk("sw_be0", s_be[0], 4'hE);
        chk("sw_wdata0", s_id[0], 32'h22334400);
        chk("sw_addr1", s_ma[1], 32'h24);
        chk("sw_be1", s_be[1], 4'h1);
        chk("sw_wdata1", s_id[1][7:0], 8'h11);
        chk("sw_we1", s_we[1], 1'b1);
        chk("sw_lat", lat, 3);
        do_req(0, 1'b0, 3'b010, 32'h21, 32'h0);
        chk("lw_split_lat", lat, 3);
        chk("lw_split_res", res, 32'h11223344);

        // LH at the top of the address space wraps to word 0
        do_req(0, 1'b0, 3'b001, 32'hFFFFFFFF, 32'h0);
        chk("wrap_nmem", n_en, 2);
        chk("wrap_addr0", s_ma[0], 32'hFFFFFFFC);
        chk("wrap_be0", s_be[0], 4'h8);
        chk("wrap_addr1", s_ma[1], 32'h0);
        chk("wrap_be1", s_be[1], 4'h1);
        chk("wrap_res", res, 32'hFFFFF1AB);

        // Illegal encodings
        do_req(0, 1'b0, 3'b011, 32'h10, 32'h0);
        chk("ill_ld_nmem", n_en, 0);
        chk("ill_ld_lat", lat, 1);
        chk("ill_ld_fault", flt, 1'b1);
        chk("ill_ld_res", res, 32'h0);
        do_req(0, 1'b1, 3'b100, 32'h10, 32'h55);
        chk("ill_st_nmem", n_en, 0);
        chk("ill_st_fault", flt, 1'b1);

        // Unit with split accesses disabled
        do_req(1, 1'b0, 3'b010, 32'h02, 32'h0);
        chk("strict_nmem", n_en, 0);
        chk("strict_lat", lat, 1);
        chk("strict_fault", flt, 1'b1);
        chk("strict_res", res, 32'h0);
        do_req(1, 1'b0, 3'b010, 32'h04, 32'h0);
        chk("strict_ok_lat", lat, 2);
        chk("strict_ok_res", res, 32'h12345678);
        chk("strict_ok_fault", flt, 1'b0);

        // Reset during the second half of a split store
        @(negedge clk);
        b1.ReqValid = 1'b1; b1.ReqWrite = 1'b1; b1.Funct3 = 3'b010;
        b1.Adress = 32'h22; b1.StoreData = 32'hCAFEBABE;
        @(posedge clk);
        #1 b1.ReqValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_acc1_memen", b1.MemEn, 1'b1);
        chk("abort_acc1_addr", b1.MemoryAdress, 32'h24);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_memen", b1.MemEn, 1'b0);
        chk("abort_ready", b1.ReqReady, 1'b1);
        pulses = (b1.RespValid === 1'b1) ? 1 : 0;
        repeat (3) begin
            @(negedge clk);
            if (b1.RespValid === 1'b1) pulses++;
        end
        chk("abort_no_resp", pulses, 0);
        do_req(0, 1'b0, 3'b010, 32'h20, 32'h0);
        chk("abort_first_half", res, 32'hBABE4400);
        do_req(0, 1'b0, 3'b010, 32'h10, 32'h0);
        chk("after_abort_lat", lat, 2);
        chk("after_abort_res", res, 32'hA5ADBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
